approx_error_monitor: RTL

Hardware response analyzer for the approximate-adder family: it is the receiving end of an adder-under-test stimulus stream.
- Each accepted sample carries operands X/Y and the adder's {Co,S}. The block recomputes the exact sum and derives the error distance (ED).
- Over a fixed window it accumulates sample count, erroneous-sample count, ED sum and max ED.
- The block sits beside an adder instance (e.g. HOERAA N=16, K=10) in on-chip characterization builds and replaces offline $monitor-based error analysis.

---
 rtl/approx_err_pkg.sv | 22 ++
 rtl/approx_error_monitor_abs_diff.sv | 13 +
 rtl/approx_error_monitor.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/approx_err_pkg.sv
// Shared types and defaults for the approximate-adder error monitor.
// Holds the FSM state encoding and the accumulator width helper.
package approx_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_N     = 16;
    localparam int DEF_WIN   = 1000;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_ACC_W = 33;

    // Width of the pre-saturation sum: the wider of accumulator and ED, plus a carry bit.
    function automatic int sat_sum_w(input int acc_w, input int n);
        return ((acc_w > n + 1) ? acc_w : n + 1) + 1;
    endfunction

endpackage

// File: rtl/approx_error_monitor_abs_diff.sv
// Unsigned absolute difference |a - b|, purely combinational.
// Zero latency; no flow control.
module abs_diff #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/approx_error_monitor.sv
// Windowed error-distance statistics for an approximate adder's {co,s} against x+y.
// Sample visible on outputs 2 cycles after accept; in_ready drops once WIN samples are taken.
module approx_error_monitor
    import approx_err_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIN   = DEF_WIN,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    input  logic [N-1:0]     s,
    input  logic             co,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N:0]       ed_max,
    output logic             ovf
);

    localparam int               SUM_W   = sat_sum_w(ACC_W, N);
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef struct packed {
        logic [N:0] exact;
        logic [N:0] approx;
    } s1_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
    logic [N:0]       ed_max_q, ed_max_d;
    logic             ovf_q, ovf_d;
    logic             s1_vld_q, s1_vld_d;
    s1_t              s1_q, s1_d;

    logic             accept;
    logic [N:0]       ed;
    logic [SUM_W-1:0] sum_w;

    abs_diff #(.W(N + 1)) u_abs_diff (
        .a (s1_q.exact),
        .b (s1_q.approx),
        .d (ed)
    );

    assign in_ready = (state_q == RUN) && (acc_cnt_q < WIN_C);
    assign accept   = in_valid && in_ready;
    assign sum_w    = SUM_W'(ed_sum_q) + SUM_W'(ed);

    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        ed_sum_d     = ed_sum_q;
        ed_max_d     = ed_max_q;
        ovf_d        = ovf_q;
        s1_vld_d     = accept;
        s1_d.exact   = {1'b0, x} + {1'b0, y};
        s1_d.approx  = {co, s};

        if (s1_vld_q) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (ed != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (ed > ed_max_q) begin
                ed_max_d = ed;
            end
            if (sum_w > SUM_W'(ACC_MAX)) begin
                ed_sum_d = ACC_MAX;
                ovf_d    = 1'b1;
            end else begin
                ed_sum_d = sum_w[ACC_W-1:0];
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    acc_cnt_d    = '0;
                    sample_cnt_d = '0;
                    err_cnt_d    = '0;
                    ed_sum_d     = '0;
                    ed_max_d     = '0;
                    ovf_d        = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == WIN_C - CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            // The last sample sits in stage 1 here and retires on this edge.
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d      = IDLE;
            acc_cnt_d    = '0;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            ed_sum_d     = '0;
            ed_max_d     = '0;
            ovf_d        = 1'b0;
            s1_vld_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_cnt_q    <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            ed_sum_q     <= '0;
            ed_max_q     <= '0;
            ovf_q        <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_q         <= '0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ed_sum_q     <= ed_sum_d;
            ed_max_q     <= ed_max_d;
            ovf_q        <= ovf_d;
            s1_vld_q     <= s1_vld_d;
            s1_q         <= s1_d;
        end
    end

    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign ed_sum     = ed_sum_q;
    assign ed_max     = ed_max_q;
    assign ovf        = ovf_q;

endmodule
